synaptic_weight_accumulator: RTL and testbench

//  Upstream stage of the per-neuron potential adder. Once per timestep, scans the latched

---
 rtl/synaptic_weight_accumulator_pkg.sv | 30 +++
 rtl/synaptic_weight_accumulator_addsub.sv | 106 ++++++++++
 rtl/synaptic_weight_accumulator.sv | 115 +++++++++++
 tb/tb_synaptic_weight_accumulator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/synaptic_weight_accumulator_pkg.sv
// Shared FP32 constants, accumulator FSM states and a leading-zero helper
// for the synaptic weight accumulator slice.
package synaptic_weight_accumulator_pkg;

    localparam logic [31:0] FP_ZERO       = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;
    localparam int unsigned N_PRE_DEFAULT = 30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_ACC,
        S_DONE
    } acc_state_t;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (!found && v[26-i]) begin
                n     = 5'(i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/synaptic_weight_accumulator_addsub.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even,
// gradual underflow; exception flags any inf or NaN result.
module Addition_Subtraction
    import synaptic_weight_accumulator_pkg::*;
(
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        op,
    output logic [31:0] result,
    output logic        exception
);

    logic        sa, sb, sx, sy, swap, sticky, round_up;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ea, eb, ex, ey, d;
    logic [22:0] ma, mb, m_fin;
    logic [23:0] gx, gy;
    logic [26:0] ax, ay_full, ay, s_norm;
    logic [27:0] sum;
    logic [9:0]  e_norm, e_fin;
    logic [4:0]  lz, sh;
    logic [24:0] rnd;

    always_comb begin
        sa = a_operand[31];
        sb = b_operand[31] ^ op;
        ea = a_operand[30:23];
        eb = b_operand[30:23];
        ma = a_operand[22:0];
        mb = b_operand[22:0];
        a_nan = (ea == 8'hFF) && (ma != '0);
        b_nan = (eb == 8'hFF) && (mb != '0);
        a_inf = (ea == 8'hFF) && (ma == '0);
        b_inf = (eb == 8'hFF) && (mb == '0);

        // x is the operand with the larger magnitude, so the subtraction never goes negative
        swap = (b_operand[30:0] > a_operand[30:0]);
        sx = swap ? sb : sa;
        sy = swap ? sa : sb;
        ex = swap ? eb : ea;
        ey = swap ? ea : eb;
        gx = {ex != 8'd0, swap ? mb : ma};
        gy = {ey != 8'd0, swap ? ma : mb};
        if (ex == 8'd0) ex = 8'd1;
        if (ey == 8'd0) ey = 8'd1;

        d       = ex - ey;
        ax      = {gx, 3'b000};
        ay_full = {gy, 3'b000};
        if (d >= 8'd27) begin
            ay     = '0;
            sticky = |gy;
        end else begin
            ay     = ay_full >> d;
            sticky = |(ay_full & ~({27{1'b1}} << d));
        end
        ay[0] = ay[0] | sticky;

        sum    = (sx == sy) ? ({1'b0, ax} + {1'b0, ay}) : ({1'b0, ax} - {1'b0, ay});
        e_norm = {2'b00, ex};
        lz     = '0;
        sh     = '0;
        if (sum[27]) begin
            s_norm = {sum[27:2], sum[1] | sum[0]};
            e_norm = e_norm + 10'd1;
        end else begin
            lz     = lzc27(sum[26:0]);
            sh     = ((e_norm - 10'd1) < {5'd0, lz}) ? (e_norm[4:0] - 5'd1) : lz;
            s_norm = sum[26:0] << sh;
            e_norm = e_norm - {5'd0, sh};
        end

        round_up = s_norm[2] & (s_norm[1] | s_norm[0] | s_norm[3]);
        rnd      = {1'b0, s_norm[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
            e_fin = e_norm + 10'd1;
            m_fin = rnd[23:1];
        end else if (rnd[23]) begin
            e_fin = e_norm;
            m_fin = rnd[22:0];
        end else begin
            e_fin = '0;
            m_fin = rnd[22:0];
        end

        exception = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            result    = FP_QNAN;
            exception = 1'b1;
        end else if (a_inf) begin
            result    = {sa, 8'hFF, 23'd0};
            exception = 1'b1;
        end else if (b_inf) begin
            result    = {sb, 8'hFF, 23'd0};
            exception = 1'b1;
        end else if (e_fin >= 10'd255) begin
            result    = {sx, 8'hFF, 23'd0};
            exception = 1'b1;
        end else if (sum == '0) begin
            result = {sx & sy, 31'd0};
        end else begin
            result = {sx, e_fin[7:0], m_fin};
        end
    end

endmodule

// File: rtl/synaptic_weight_accumulator.sv
// Scans the latched spike vector once per timestep and serially sums the FP32
// weights of spiking inputs in ascending index order.
module synaptic_weight_accumulator
    import synaptic_weight_accumulator_pkg::*;
#(
    parameter int unsigned       N_PRE    = N_PRE_DEFAULT,
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] ROW_BASE = '0
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [N_PRE-1:0]  spike_in,
    output logic              weight_rd_en,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [31:0]       weight_data,
    output logic [31:0]       acc_weight,
    output logic              busy,
    output logic              done,
    output logic              exc
);

    localparam int unsigned      IDX_W = (N_PRE > 1) ? $clog2(N_PRE) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_PRE - 1);

    acc_state_t        state, state_d;
    logic [IDX_W-1:0]  index, index_d;
    logic [N_PRE-1:0]  spikes, spikes_d;
    logic [31:0]       acc_d, sum;
    logic              exc_d, sum_exc;
    logic              rd_en_d, busy_d, done_d;
    logic [ADDR_W-1:0] addr_d;

    Addition_Subtraction u_add (
        .a_operand (acc_weight),
        .b_operand (weight_data),
        .op        (1'b0),
        .result    (sum),
        .exception (sum_exc)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            index        <= '0;
            spikes       <= '0;
            acc_weight   <= FP_ZERO;
            exc          <= 1'b0;
            weight_rd_en <= 1'b0;
            weight_addr  <= ROW_BASE;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            index        <= index_d;
            spikes       <= spikes_d;
            acc_weight   <= acc_d;
            exc          <= exc_d;
            weight_rd_en <= rd_en_d;
            weight_addr  <= addr_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_d  = state;
        index_d  = index;
        spikes_d = spikes;
        acc_d    = acc_weight;
        exc_d    = exc;
        case (state)
            S_IDLE: begin
                if (start) begin
                    spikes_d = spike_in;
                    acc_d    = FP_ZERO;
                    exc_d    = 1'b0;
                    index_d  = '0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (spikes[index]) begin
                    state_d = S_ACC;
                end else if (index == LAST) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index + 1'b1;
                end
            end
            S_ACC: begin
                acc_d = sum;
                exc_d = exc | sum_exc;
                if (index == LAST) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index + 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it and
    // the read strobe lands in the SCAN cycle, one cycle ahead of ACC.
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        rd_en_d = (state_d == S_SCAN) && spikes_d[index_d];
        addr_d  = ROW_BASE + ADDR_W'(index_d);
    end

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
// Randomised and directed bench for synaptic_weight_accumulator with a
// weight-memory responder and an integer-arithmetic reference for the sums.
module tb_synaptic_weight_accumulator;

    localparam int unsigned N_PRE    = 30;
    localparam int unsigned ADDR_W   = 8;
    localparam logic [7:0]  ROW_BASE = 8'd16;

    logic              CLK = 1'b0;
    logic              rst;
    logic              start;
    logic [N_PRE-1:0]  spike_in;
    logic              weight_rd_en;
    logic [ADDR_W-1:0] weight_addr;
    logic [31:0]       weight_data;
    logic [31:0]       acc_weight;
    logic              busy, done, exc;

    logic [31:0] mem [0:N_PRE-1];
    int          wq  [0:N_PRE-1];
    int          checks   = 0;
    int          failures = 0;

    synaptic_weight_accumulator #(
        .N_PRE    (N_PRE),
        .ADDR_W   (ADDR_W),
        .ROW_BASE (ROW_BASE)
    ) dut (
        .CLK          (CLK),
        .rst          (rst),
        .start        (start),
        .spike_in     (spike_in),
        .weight_rd_en (weight_rd_en),
        .weight_addr  (weight_addr),
        .weight_data  (weight_data),
        .acc_weight   (acc_weight),
        .busy         (busy),
        .done         (done),
        .exc          (exc)
    );

    always #5 CLK = ~CLK;

    // Synchronous weight memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge CLK) begin
        if (weight_rd_en && weight_addr >= ROW_BASE && weight_addr < ROW_BASE + 8'(N_PRE))
            weight_data <= mem[weight_addr - ROW_BASE];
        else
            weight_data <= $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // FP32 encoding of q/4 for |q| < 2^20
    function automatic logic [31:0] fp_q(input int q);
        int unsigned mag;
        int          p;
        logic [31:0] m;
        if (q == 0) return 32'h0;
        mag = (q < 0) ? -q : q;
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        m = 32'(mag) << (23 - p);
        return {q < 0, 8'(127 + p - 2), m[22:0]};
    endfunction

    function automatic logic [31:0] model_sum(input logic [N_PRE-1:0] spk);
        int total = 0;
        for (int i = 0; i < N_PRE; i++) if (spk[i]) total += wq[i];
        return fp_q(total);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N_PRE; i++) begin
            wq[i]  = int'($urandom_range(0, 8000)) - 4000;
            mem[i] = fp_q(wq[i]);
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_ts(input string tag, input logic [N_PRE-1:0] spk, input logic [31:0] exp_acc,
                          input logic exp_exc, input bit poke_busy, input bit poke_done);
        int unsigned       lat = N_PRE + $countones(spk) + 1;
        int unsigned       n;
        bit                seen;
        int                bad;
        logic [ADDR_W-1:0] exp_addrs[$];
        logic [ADDR_W-1:0] got_addrs[$];
        for (int i = 0; i < N_PRE; i++) if (spk[i]) exp_addrs.push_back(ROW_BASE + 8'(i));
        start    = 1'b1;
        spike_in = spk;
        @(negedge CLK);
        start = 1'b0;
        n     = 1;
        seen  = 1'b0;
        check({tag, "/busy_start"}, 32'(busy), 32'd1);
        check({tag, "/acc_start"}, acc_weight, 32'h0);
        check({tag, "/exc_start"}, 32'(exc), 32'd0);
        while (!seen && n <= lat + 5) begin
            if (weight_rd_en) got_addrs.push_back(weight_addr);
            if (done) begin
                seen = 1'b1;
            end else begin
                start    = poke_busy && (n == 3);
                spike_in = N_PRE'($urandom);
                @(negedge CLK);
                n++;
            end
        end
        start = 1'b0;
        check({tag, "/latency"}, seen ? 32'(n) : 32'd0, 32'(lat));
        check({tag, "/acc"}, acc_weight, exp_acc);
        check({tag, "/exc"}, 32'(exc), 32'(exp_exc));
        check({tag, "/busy_done"}, 32'(busy), 32'd1);
        bad = (got_addrs.size() == exp_addrs.size()) ? 0 : 1;
        if (bad == 0)
            for (int i = 0; i < exp_addrs.size(); i++) if (got_addrs[i] !== exp_addrs[i]) bad++;
        check({tag, "/read_addrs"}, 32'(bad), 32'd0);
        if (poke_done) start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
        check({tag, "/idle"}, 32'(busy), 32'd0);
        check({tag, "/acc_hold"}, acc_weight, exp_acc);
        if (poke_done) begin
            @(negedge CLK);
            check({tag, "/start_in_done_ignored"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [N_PRE-1:0] spk;
        int               rd_cnt, waited, k;

        rst      = 1'b1;
        start    = 1'b0;
        spike_in = '0;
        fill_random();
        #1;
        check("reset/acc", acc_weight, 32'h0);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/exc", 32'(exc), 32'd0);
        check("reset/rd_en", 32'(weight_rd_en), 32'd0);
        check("reset/addr", 32'(weight_addr), 32'(ROW_BASE));
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);

        run_ts("t1_nospike", '0, 32'h0, 1'b0, 1'b0, 1'b0);

        mem[0] = 32'h3F80_0000;
        mem[2] = 32'h3F80_0000;
        spk = '0; spk[0] = 1'b1; spk[2] = 1'b1;
        run_ts("t2_bits02", spk, 32'h4000_0000, 1'b0, 1'b0, 1'b0);

        mem[29] = 32'h4220_0000;
        spk = '0; spk[29] = 1'b1;
        run_ts("t3_bit29", spk, 32'h4220_0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N_PRE; i++) mem[i] = 32'h3F80_0000;
        run_ts("t4_all_busy_start", '1, 32'h41F0_0000, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a scan
        start    = 1'b1;
        spike_in = '1;
        @(negedge CLK);
        start  = 1'b0;
        rd_cnt = 0;
        waited = 0;
        while (rd_cnt < 2 && waited < 20) begin
            if (weight_rd_en) rd_cnt++;
            if (rd_cnt < 2) begin
                @(negedge CLK);
                waited++;
            end
        end
        check("t5/second_read", 32'(rd_cnt), 32'd2);
        check("t5/partial_acc", acc_weight, 32'h3F80_0000);
        #2 rst = 1'b1;
        #1;
        check("t5/acc", acc_weight, 32'h0);
        check("t5/busy", 32'(busy), 32'd0);
        check("t5/rd_en", 32'(weight_rd_en), 32'd0);
        check("t5/addr", 32'(weight_addr), 32'(ROW_BASE));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("t5/no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(negedge CLK);
        fill_random();
        spk = N_PRE'($urandom);
        run_ts("t5_after_reset", spk, model_sum(spk), 1'b0, 1'b0, 1'b0);

        fill_random();
        k = int'($urandom_range(0, N_PRE - 1));
        mem[k] = 32'h7F80_0000;
        spk = N_PRE'($urandom);
        spk[k] = 1'b1;
        run_ts("t6_inf", spk, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);

        fill_random();
        spk = N_PRE'($urandom);
        run_ts("t6_exc_cleared", spk, model_sum(spk), 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            spk = N_PRE'($urandom) & N_PRE'($urandom | (r < 4 ? 0 : 32'hFFFF_FFFF));
            run_ts("rand", spk, model_sum(spk), 1'b0, 1'b0, 1'b0);
        end

        // Cancellation: x + (-x) must give +0
        fill_random();
        wq[3] = 1234; mem[3] = fp_q(1234);
        wq[7] = -1234; mem[7] = fp_q(-1234);
        spk = '0; spk[3] = 1'b1; spk[7] = 1'b1;
        run_ts("cancel", spk, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
